// File: rtl/stage_execute_mc.sv
// Execute stage: single-cycle ALU/branch resolution plus an iterative mul/div unit
// that stalls the front end until its result is ready.
module stage_execute_mc #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TARGET_BITS = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [31:0]      insn,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       bypass_sel_A,
  input  logic [1:0]       bypass_sel_B,
  input  logic [WIDTH-1:0] xm_data,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic             stall,
  output logic             take_branch,
  output logic [WIDTH-1:0] pc_target,
  output logic             write_exception
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic              neg_q, neg_d, div_q, div_d, dexc_q, dexc_d;

  // Decode
  logic [4:0] opcode, alu_op, shamt;
  logic is_r, is_addi, is_sw, is_lw, is_bne, is_blt, is_j, is_jal, is_jr, is_bex, is_setx;
  logic is_mul, is_div, is_muldiv;

  assign opcode    = insn[31:27];
  assign alu_op    = insn[6:2];
  assign shamt     = insn[11:7];
  assign is_r      = (opcode == 5'b00000);
  assign is_addi   = (opcode == 5'b00101);
  assign is_sw     = (opcode == 5'b00111);
  assign is_lw     = (opcode == 5'b01000);
  assign is_bne    = (opcode == 5'b00010);
  assign is_blt    = (opcode == 5'b00110);
  assign is_j      = (opcode == 5'b00001);
  assign is_jal    = (opcode == 5'b00011);
  assign is_jr     = (opcode == 5'b00100);
  assign is_bex    = (opcode == 5'b10110);
  assign is_setx   = (opcode == 5'b10101);
  assign is_mul    = is_r && (alu_op == 5'b00110);
  assign is_div    = is_r && (alu_op == 5'b00111);
  assign is_muldiv = is_mul || is_div;

  logic [WIDTH-1:0] imm_ext, jump_pc, a_eff, b_eff, alu_b;

  assign imm_ext = {{(WIDTH-17){insn[16]}}, insn[16:0]};
  assign jump_pc = {pc[WIDTH-1:TARGET_BITS], insn[TARGET_BITS-1:0]};

  // M->X forwarding takes priority over W->X
  assign a_eff = bypass_sel_A[1] ? xm_data : (bypass_sel_A[0] ? wb_data : regA);
  assign b_eff = bypass_sel_B[1] ? xm_data : (bypass_sel_B[0] ? wb_data : regB);
  assign alu_b = (is_addi || is_lw || is_sw) ? imm_ext : (is_bex ? '0 : b_eff);

  // Single-cycle ALU
  logic [WIDTH-1:0] sum, diff, alu_res, sc_out;
  logic             add_ovf, sub_ovf, alu_exc;
  logic [WIDTH-1:0] alu_code;

  assign sum     = a_eff + alu_b;
  assign diff    = a_eff - b_eff;
  assign add_ovf = (a_eff[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
  assign sub_ovf = (a_eff[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != a_eff[WIDTH-1]);

  always_comb begin
    alu_res  = sum;
    alu_exc  = 1'b0;
    alu_code = '0;
    if (is_r) begin
      unique case (alu_op)
        5'b00000: begin alu_res = sum;  alu_exc = add_ovf; alu_code = WIDTH'(1); end
        5'b00001: begin alu_res = diff; alu_exc = sub_ovf; alu_code = WIDTH'(3); end
        5'b00010: alu_res = a_eff & b_eff;
        5'b00011: alu_res = a_eff | b_eff;
        5'b00100: alu_res = a_eff << shamt;
        5'b00101: alu_res = $signed(a_eff) >>> shamt;
        default:  alu_res = '0;
      endcase
    end else if (is_addi) begin
      alu_exc  = add_ovf;
      alu_code = WIDTH'(2);
    end
  end

  always_comb begin
    if (is_jal)       sc_out = pc;
    else if (alu_exc) sc_out = alu_code;
    else if (is_setx) sc_out = jump_pc;
    else              sc_out = alu_res;
  end

  // Branch resolution
  logic             br_cond;
  logic [WIDTH-1:0] br_target;

  assign br_cond = (is_bne && (a_eff != b_eff)) ||
                   (is_blt && ($signed(a_eff) > $signed(b_eff))) ||
                   (is_bex && (b_eff != '0)) ||
                   is_j || is_jal || is_jr;
  assign br_target = (is_bne || is_blt) ? (pc + imm_ext) : (is_jr ? b_eff : jump_pc);

  // Iterative unit: magnitudes in, sign re-applied at the end
  logic [WIDTH-1:0] a_abs, b_abs, md_mag, md_res, md_code;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic             div0, div_min, mul_ovf, md_exc;

  assign a_abs     = a_eff[WIDTH-1] ? -a_eff : a_eff;
  assign b_abs     = b_eff[WIDTH-1] ? -b_eff : b_eff;
  assign div0      = (b_eff == '0);
  assign div_min   = (a_eff == {1'b1, {(WIDTH-1){1'b0}}}) && (b_eff == '1);
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not
  assign mul_ovf = (hi_q != '0) ||
                   (lo_q[WIDTH-1] && (!neg_q || (lo_q[WIDTH-2:0] != '0)));
  assign md_mag  = (div_q && dexc_q) ? '0 : lo_q;
  assign md_res  = neg_q ? -md_mag : md_mag;
  assign md_exc  = div_q ? dexc_q : mul_ovf;
  assign md_code = div_q ? WIDTH'(5) : WIDTH'(4);

  logic             stall_c, ov_c, tb_c, exc_c;
  logic [WIDTH-1:0] o_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    div_d   = div_q;
    dexc_d  = dexc_q;
    stall_c = 1'b0;
    ov_c    = 1'b0;
    tb_c    = 1'b0;
    exc_c   = 1'b0;
    o_c     = '0;
    unique case (state_q)
      StIdle: begin
        o_c   = sc_out;
        exc_c = alu_exc;
        if (in_valid && is_muldiv && !flush) begin
          stall_c = 1'b1;
          state_d = StBusy;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = is_mul ? b_abs : a_abs;
          opnd_d  = is_mul ? a_abs : b_abs;
          neg_d   = a_eff[WIDTH-1] ^ b_eff[WIDTH-1];
          div_d   = is_div;
          dexc_d  = is_div && (div0 || div_min);
        end else begin
          ov_c = in_valid && !flush;
          tb_c = in_valid && !flush && br_cond;
        end
      end
      StBusy: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if (div_q) begin
          hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (flush)                          state_d = StIdle;
        else if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        ov_c    = !flush;
        exc_c   = md_exc;
        o_c     = md_exc ? md_code : md_res;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      dexc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      dexc_q  <= dexc_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the clock
  assign o_out           = reset ? o_c : '0;
  assign b_out           = reset ? b_eff : '0;
  assign out_valid       = reset && ov_c;
  assign stall           = reset && stall_c;
  assign take_branch     = reset && tb_c;
  assign pc_target       = reset ? br_target : '0;
  assign write_exception = reset && exc_c && ov_c;

endmodule

// File: tb/tb_stage_execute_mc.sv
// Bench for stage_execute_mc: table of single-cycle vectors plus mul/div, flush and
// reset sequences, with a scoreboard queue matched against out_valid.
module tb_stage_execute_mc;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, flush;
  logic [31:0]   insn;
  logic [W-1:0]  regA, regB, pc, xm_data, wb_data;
  logic [1:0]    bypass_sel_A, bypass_sel_B;
  logic [W-1:0]  o_out, b_out, pc_target;
  logic          out_valid, stall, take_branch, write_exception;

  stage_execute_mc #(.WIDTH(W), .TARGET_BITS(27)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .flush           (flush),
    .insn            (insn),
    .regA            (regA),
    .regB            (regB),
    .pc              (pc),
    .bypass_sel_A    (bypass_sel_A),
    .bypass_sel_B    (bypass_sel_B),
    .xm_data         (xm_data),
    .wb_data         (wb_data),
    .o_out           (o_out),
    .b_out           (b_out),
    .out_valid       (out_valid),
    .stall           (stall),
    .take_branch     (take_branch),
    .pc_target       (pc_target),
    .write_exception (write_exception)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] o;
    logic        exc;
    logic        chk_o;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] insn, a, b, pc, xm, wb;
    logic [1:0]  sa, sb;
    logic [31:0] exp_o;
    logic        chk_o, exp_exc, exp_tb;
    logic [31:0] exp_tgt;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [4:0] OpR = 5'b00000, OpAddi = 5'b00101, OpLw = 5'b01000;
  localparam logic [4:0] OpBne = 5'b00010, OpBlt = 5'b00110, OpJ = 5'b00001, OpJal = 5'b00011;
  localparam logic [4:0] OpJr = 5'b00100, OpBex = 5'b10110, OpSetx = 5'b10101;
  localparam logic [4:0] AluAdd = 5'd0, AluSub = 5'd1, AluAnd = 5'd2, AluOr = 5'd3;
  localparam logic [4:0] AluSll = 5'd4, AluSra = 5'd5, AluMul = 5'd6, AluDiv = 5'd7;

  function automatic logic [31:0] r_op(input logic [4:0] aop, input logic [4:0] sh);
    return {OpR, 5'd1, 5'd2, 5'd3, sh, aop, 2'b00};
  endfunction

  function automatic logic [31:0] i_op(input logic [4:0] op, input logic [16:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [4:0] op, input logic [26:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [31:0] xm, input logic [31:0] wb,
                         input logic [31:0] eo, input logic co, input logic ee,
                         input logic etb, input logic [31:0] etg);
    vec_t v;
    v.name = name; v.insn = ins; v.a = a; v.b = b; v.pc = p; v.sa = sa; v.sb = sb;
    v.xm = xm; v.wb = wb; v.exp_o = eo; v.chk_o = co; v.exp_exc = ee; v.exp_tb = etb;
    v.exp_tgt = etg;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input logic [31:0] o, input logic exc,
                          input logic chk_o);
    exp_t e;
    e.name = name; e.o = o; e.exc = exc; e.chk_o = chk_o;
    exp_q.push_back(e);
  endtask

  // Sample at the falling edge; any out_valid must match the oldest expectation
  task automatic sb_sample();
    exp_t e;
    @(negedge clock);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 (o_out=0x%0h), expected 0", o_out);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_o) check({e.name, "_o_out"}, 64'(o_out), 64'(e.o));
        check({e.name, "_write_exception"}, 64'(write_exception), 64'(e.exc));
      end
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; flush = 1'b0; insn = '0; regA = '0; regB = '0; pc = '0;
    bypass_sel_A = 2'b00; bypass_sel_B = 2'b00; xm_data = '0; wb_data = '0;
  endtask

  task automatic issue_muldiv(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    drive_idle();
    in_valid = 1'b1;
    insn     = r_op(is_div ? AluDiv : AluMul, 5'd0);
    regA     = a;
    regB     = b;
  endtask

  // Issues at the next cycle t and follows it until out_valid; no trailing idle cycle
  task automatic run_muldiv(input string name, input logic is_div, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eo, input logic ee);
    int  stall_cnt;
    int  lat;
    bit  done;
    stall_cnt = 0;
    lat       = 0;
    done      = 1'b0;
    @(posedge clock); #1;
    issue_muldiv(is_div, a, b);
    push_exp(name, eo, ee, 1'b1);
    for (int c = 0; c < 100; c++) begin
      sb_sample();
      if (out_valid === 1'b1) begin
        done = 1'b1;
        lat  = c;
        check({name, "_stall_in_done"}, 64'(stall), 64'd0);
        break;
      end
      if (stall === 1'b1) stall_cnt++;
      @(posedge clock); #1;
      // Captured operands must not depend on later bypass inputs
      regA = $urandom; regB = $urandom; xm_data = $urandom; wb_data = $urandom;
    end
    check({name, "_completed"}, 64'(done), 64'd1);
    if (!done && exp_q.size() != 0) void'(exp_q.pop_front());
    check({name, "_latency"}, 64'(lat), 64'(W + 1));
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(W + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live mul presented: every output must read zero
    reset = 1'b0;
    drive_idle();
    in_valid = 1'b1;
    insn     = r_op(AluMul, 5'd0);
    regA     = 32'd7;
    regB     = 32'd3;
    @(negedge clock);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_o_out", 64'(o_out), 64'd0);
    check("reset_take_branch", 64'(take_branch), 64'd0);
    drive_idle();
    @(negedge clock);
    reset = 1'b1;

    add_vec("add_ovf", r_op(AluAdd, 0), 32'h7FFFFFFF, 32'd1, 0, 2'b00, 2'b00, 0, 0,
            32'd1, 1, 1, 0, 0);
    add_vec("add", r_op(AluAdd, 0), 32'd5, 32'd3, 0, 2'b00, 2'b00, 0, 0, 32'd8, 1, 0, 0, 0);
    add_vec("add_selB_xm", r_op(AluAdd, 0), 32'd2, 32'd99, 0, 2'b00, 2'b10, 32'd40, 32'd7,
            32'd42, 1, 0, 0, 0);
    add_vec("sub_ovf", r_op(AluSub, 0), 32'h80000000, 32'd1, 0, 2'b00, 2'b00, 0, 0,
            32'd3, 1, 1, 0, 0);
    add_vec("sub", r_op(AluSub, 0), 32'd10, 32'd3, 0, 2'b00, 2'b00, 0, 0, 32'd7, 1, 0, 0, 0);
    add_vec("and", r_op(AluAnd, 0), 32'hF0F0, 32'hFF00, 0, 2'b00, 2'b00, 0, 0,
            32'hF000, 1, 0, 0, 0);
    add_vec("or", r_op(AluOr, 0), 32'hF0F0, 32'h0F00, 0, 2'b00, 2'b00, 0, 0,
            32'hFFF0, 1, 0, 0, 0);
    add_vec("sll", r_op(AluSll, 5'd4), 32'd1, 0, 0, 2'b00, 2'b00, 0, 0, 32'h10, 1, 0, 0, 0);
    add_vec("sra", r_op(AluSra, 5'd4), 32'h80000000, 0, 0, 2'b00, 2'b00, 0, 0,
            32'hF8000000, 1, 0, 0, 0);
    add_vec("addi_byp_m", i_op(OpAddi, 17'd1), 32'd1, 0, 0, 2'b11, 2'b00, 32'd9, 32'd4,
            32'd10, 1, 0, 0, 0);
    add_vec("addi_byp_w", i_op(OpAddi, 17'd1), 32'd1, 0, 0, 2'b01, 2'b00, 32'd9, 32'd4,
            32'd5, 1, 0, 0, 0);
    add_vec("addi_ovf", i_op(OpAddi, 17'd1), 32'h7FFFFFFF, 0, 0, 2'b00, 2'b00, 0, 0,
            32'd2, 1, 1, 0, 0);
    add_vec("addi_neg", i_op(OpAddi, 17'h1FFFF), 32'd0, 0, 0, 2'b00, 2'b00, 0, 0,
            32'hFFFFFFFF, 1, 0, 0, 0);
    add_vec("lw_addr", i_op(OpLw, 17'h1FFFC), 32'h100, 0, 0, 2'b00, 2'b00, 0, 0,
            32'hFC, 1, 0, 0, 0);
    add_vec("blt_taken", i_op(OpBlt, 17'h1FFFC), 32'd5, 32'd3, 32'h10, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 1, 32'h0C);
    add_vec("blt_not", i_op(OpBlt, 17'h1FFFC), 32'd3, 32'd5, 32'h10, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 0, 0);
    add_vec("blt_signed", i_op(OpBlt, 17'd4), 32'hFFFFFFFF, 32'd1, 32'h10, 2'b00, 2'b00,
            0, 0, 0, 0, 0, 0, 0);
    add_vec("bne_taken", i_op(OpBne, 17'd8), 32'd1, 32'd2, 32'h100, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 1, 32'h108);
    add_vec("bne_not", i_op(OpBne, 17'd8), 32'd2, 32'd2, 32'h100, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 0, 0);
    add_vec("j", j_op(OpJ, 27'h123), 0, 0, 32'hF8000010, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 1, 32'hF8000123);
    add_vec("jal", j_op(OpJal, 27'h40), 0, 0, 32'h20, 2'b00, 2'b00, 0, 0,
            32'h20, 1, 0, 1, 32'h40);
    add_vec("jr", j_op(OpJr, 27'h0), 0, 32'h55, 32'h20, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 1, 32'h55);
    add_vec("bex_not", j_op(OpBex, 27'h77), 0, 32'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add_vec("bex_taken", j_op(OpBex, 27'h77), 0, 32'd1, 0, 2'b00, 2'b00, 0, 0,
            0, 0, 0, 1, 32'h77);
    add_vec("setx", j_op(OpSetx, 27'h1234), 0, 0, 32'h08000000, 2'b00, 2'b00, 0, 0,
            32'h08001234, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      logic [31:0] exp_b;
      @(posedge clock); #1;
      drive_idle();
      in_valid = 1'b1;
      insn = vecs[i].insn; regA = vecs[i].a; regB = vecs[i].b; pc = vecs[i].pc;
      bypass_sel_A = vecs[i].sa; bypass_sel_B = vecs[i].sb;
      xm_data = vecs[i].xm; wb_data = vecs[i].wb;
      exp_b = vecs[i].sb[1] ? vecs[i].xm : (vecs[i].sb[0] ? vecs[i].wb : vecs[i].b);
      push_exp(vecs[i].name, vecs[i].exp_o, vecs[i].exp_exc, vecs[i].chk_o);
      sb_sample();
      check({vecs[i].name, "_out_valid"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, "_stall"}, 64'(stall), 64'd0);
      check({vecs[i].name, "_take_branch"}, 64'(take_branch), 64'(vecs[i].exp_tb));
      check({vecs[i].name, "_b_out"}, 64'(b_out), 64'(exp_b));
      if (vecs[i].exp_tb) check({vecs[i].name, "_pc_target"}, 64'(pc_target),
                                64'(vecs[i].exp_tgt));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end

    // Back-to-back mul/div sequences
    run_muldiv("mul_7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_muldiv("div_100/0", 1'b1, 32'd100, 32'd0, 32'd5, 1'b1);
    run_muldiv("div_-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    run_muldiv("div_100/7", 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
    run_muldiv("div_min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_muldiv("mul_ovf", 1'b0, 32'h10000, 32'h10000, 32'd4, 1'b1);
    run_muldiv("mul_min_fits", 1'b0, 32'hFFFF0000, 32'h8000, 32'h80000000, 1'b0);

    // Flush while busy: no result, stall drops the cycle after the flush edge
    @(posedge clock); #1;
    issue_muldiv(1'b0, 32'd3, 32'd4);
    sb_sample();
    repeat (9) begin
      @(posedge clock); #1;
      sb_sample();
    end
    @(posedge clock); #1;
    flush = 1'b1;
    sb_sample();
    check("flush_busy_stall_held", 64'(stall), 64'd1);
    check("flush_busy_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    drive_idle();
    in_valid = 1'b1;
    insn     = i_op(OpAddi, 17'd5);
    push_exp("addi_after_flush", 32'd5, 1'b0, 1'b1);
    sb_sample();
    check("after_flush_stall", 64'(stall), 64'd0);
    check("after_flush_out_valid", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
    drive_idle();
    repeat (40) sb_sample();

    // Flush landing exactly on the result cycle suppresses it
    @(posedge clock); #1;
    issue_muldiv(1'b0, 32'd2, 32'd3);
    sb_sample();
    repeat (W) begin
      @(posedge clock); #1;
      sb_sample();
    end
    @(posedge clock); #1;
    flush = 1'b1;
    sb_sample();
    check("flush_done_out_valid", 64'(out_valid), 64'd0);
    check("flush_done_stall", 64'(stall), 64'd0);
    @(posedge clock); #1;
    drive_idle();
    repeat (3) sb_sample();

    // Asynchronous reset in the middle of a busy mul
    @(posedge clock); #1;
    issue_muldiv(1'b0, 32'd5, 32'd6);
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("pre_reset_busy_stall", 64'(stall), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_stall", 64'(stall), 64'd0);
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    drive_idle();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) sb_sample();
    run_muldiv("mul_after_reset", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    @(posedge clock); #1;
    drive_idle();
    repeat (3) sb_sample();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
